exe_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one execution-unit datapath (comparator/ALU, combinational or fixed-latency) between N requesters. It accepts one operation at a time and registers the operands and opcode. It drives the shared unit and holds its inputs stable for EXE_LAT cycles. It then captures the result and returns it to the winning requester tagged with that requester's ID. It sits between the requester ports of the execution unit and the shared datapath instance.

---
 rtl/exe_arb_pkg.sv | 23 ++
 rtl/exe_arb_rr_pick.sv | 43 ++++
 rtl/exe_arbiter.sv | 141 ++++++++++++++
 tb/tb_exe_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_arb_pkg.sv
// Shared definitions for the execution-unit arbiter: FSM states, the default
// opcode width and the opcode encodings understood by the shared datapath.
package exe_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int OPW_DEF = 3;

    // Opcodes shared with the execution unit; comparisons return 0/1 in bit 0.
    localparam logic [OPW_DEF-1:0] OP_CMP_EQ  = 3'd0;
    localparam logic [OPW_DEF-1:0] OP_CMP_LT  = 3'd1;
    localparam logic [OPW_DEF-1:0] OP_CMP_LTU = 3'd2;
    localparam logic [OPW_DEF-1:0] OP_ADD     = 3'd3;
    localparam logic [OPW_DEF-1:0] OP_SUB     = 3'd4;
    localparam logic [OPW_DEF-1:0] OP_AND     = 3'd5;
    localparam logic [OPW_DEF-1:0] OP_OR      = 3'd6;
    localparam logic [OPW_DEF-1:0] OP_XOR     = 3'd7;

endpackage

// File: rtl/exe_arb_rr_pick.sv
// Combinational requester picker. Round-robin by default: the first set
// request at or above ptr wins, wrapping from N-1 to 0.
// Build option EXE_ARB_PRIO_EN: fixed priority, lowest index wins, ptr ignored.
module exe_arb_rr_pick #(
    parameter int N = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] id
);

    int base;

`ifdef EXE_ARB_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;
    assign base = 0;
`else
    assign base = int'(ptr);
`endif

    // Scan upward from base with wrap; first hit becomes the one-hot winner.
    always_comb begin
        int  idx;
        logic found;
        gnt   = '0;
        id    = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = base + i;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                id       = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/exe_arbiter.sv
// Round-robin arbiter/sequencer sharing one execution unit between N
// requesters. One operation in flight: operands are latched on grant, held on
// o_exe_* for EXE_LAT cycles, then the result is returned tagged with the ID.
// Build option EXE_ARB_PRIO_EN selects fixed (lowest index) priority.
module exe_arbiter
    import exe_arb_pkg::*;
#(
    parameter int BITS    = 32,
    parameter int N       = 4,
    parameter int OPW     = OPW_DEF,
    parameter int EXE_LAT = 1,
    localparam int IDW    = $clog2(N)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N-1:0]      i_req,
    input  logic [N*BITS-1:0] i_argA,
    input  logic [N*BITS-1:0] i_argB,
    input  logic [N*OPW-1:0]  i_oper,
    output logic [N-1:0]      o_gnt,
    output logic [BITS-1:0]   o_exe_argA,
    output logic [BITS-1:0]   o_exe_argB,
    output logic [OPW-1:0]    o_exe_oper,
    input  logic [BITS-1:0]   i_exe_result,
    output logic              o_valid,
    output logic [IDW-1:0]    o_id,
    output logic [BITS-1:0]   o_result,
    input  logic              i_ready,
    output logic              o_busy
);

    // Counter only has to hold EXE_LAT-1.
    localparam int CW = (EXE_LAT > 1) ? $clog2(EXE_LAT) : 1;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [BITS-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [OPW-1:0] op_q, op_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [N-1:0]   pick_gnt;
    logic [IDW-1:0] pick_id;

    exe_arb_rr_pick #(
        .N (N)
    ) u_pick (
        .req (i_req),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .id  (pick_id)
    );

    // Next-state, operand latch and grant decode.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        o_gnt   = '0;
        unique case (state_q)
            IDLE: begin
                if (|i_req) begin
                    o_gnt   = pick_gnt;
                    a_d     = i_argA[pick_id*BITS +: BITS];
                    b_d     = i_argB[pick_id*BITS +: BITS];
                    op_d    = i_oper[pick_id*OPW +: OPW];
                    id_d    = pick_id;
                    cnt_d   = CW'(EXE_LAT - 1);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    res_d   = i_exe_result;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (i_ready) begin
`ifdef EXE_ARB_PRIO_EN
                    ptr_d = '0;
`else
                    ptr_d = (id_q == IDW'(N - 1)) ? '0 : id_q + 1'b1;
`endif
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Grant is combinational from i_req; keep it quiet while reset is held.
        if (i_rst) o_gnt = '0;
    end

    // State and datapath registers; reset drops any operation in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
        end
    end

    // Shared-unit inputs are only driven while executing.
    always_comb begin
        o_exe_argA = '0;
        o_exe_argB = '0;
        o_exe_oper = '0;
        if (state_q == EXEC) begin
            o_exe_argA = a_q;
            o_exe_argB = b_q;
            o_exe_oper = op_q;
        end
    end

    assign o_valid  = (state_q == RESP);
    assign o_busy   = (state_q != IDLE);
    assign o_id     = id_q;
    assign o_result = res_q;

endmodule

// File: tb/tb_exe_arbiter.sv
// Directed bench for exe_arbiter: one instance with EXE_LAT=1, one with
// EXE_LAT=4. A behavioural execution unit closes the loop on each instance.
module tb_exe_arbiter;
    import exe_arb_pkg::*;

    localparam int BITS = 32;
    localparam int N    = 4;
    localparam int OPW  = 3;
    localparam int IDW  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance with EXE_LAT=1
    logic              rst1;
    logic [N-1:0]      req1;
    logic [N*BITS-1:0] a1, b1;
    logic [N*OPW-1:0]  op1;
    logic [N-1:0]      gnt1;
    logic [BITS-1:0]   ea1, eb1, res1, out1;
    logic [OPW-1:0]    eop1;
    logic              valid1, ready1, busy1;
    logic [IDW-1:0]    id1;

    // Instance with EXE_LAT=4
    logic              rst4;
    logic [N-1:0]      req4;
    logic [N*BITS-1:0] a4, b4;
    logic [N*OPW-1:0]  op4;
    logic [N-1:0]      gnt4;
    logic [BITS-1:0]   ea4, eb4, res4, out4;
    logic [OPW-1:0]    eop4;
    logic              valid4, ready4, busy4;
    logic [IDW-1:0]    id4;

    exe_arbiter #(.BITS(BITS), .N(N), .OPW(OPW), .EXE_LAT(1)) dut1 (
        .i_clk(clk), .i_rst(rst1), .i_req(req1), .i_argA(a1), .i_argB(b1),
        .i_oper(op1), .o_gnt(gnt1), .o_exe_argA(ea1), .o_exe_argB(eb1),
        .o_exe_oper(eop1), .i_exe_result(res1), .o_valid(valid1), .o_id(id1),
        .o_result(out1), .i_ready(ready1), .o_busy(busy1)
    );

    exe_arbiter #(.BITS(BITS), .N(N), .OPW(OPW), .EXE_LAT(4)) dut4 (
        .i_clk(clk), .i_rst(rst4), .i_req(req4), .i_argA(a4), .i_argB(b4),
        .i_oper(op4), .o_gnt(gnt4), .o_exe_argA(ea4), .o_exe_argB(eb4),
        .o_exe_oper(eop4), .i_exe_result(res4), .o_valid(valid4), .o_id(id4),
        .o_result(out4), .i_ready(ready4), .o_busy(busy4)
    );

    function automatic logic [31:0] exe_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] op);
        case (op)
            OP_CMP_EQ:  return {31'd0, a == b};
            OP_CMP_LT:  return {31'd0, $signed(a) < $signed(b)};
            OP_CMP_LTU: return {31'd0, a < b};
            OP_ADD:     return a + b;
            OP_SUB:     return a - b;
            OP_AND:     return a & b;
            OP_OR:      return a | b;
            default:    return a ^ b;
        endcase
    endfunction

    assign res1 = exe_model(ea1, eb1, eop1);
    assign res4 = exe_model(ea4, eb4, eop4);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set1(input int r, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op);
        a1[r*BITS +: BITS] = a;
        b1[r*BITS +: BITS] = b;
        op1[r*OPW +: OPW]  = op;
    endtask

    task automatic set4(input int r, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op);
        a4[r*BITS +: BITS] = a;
        b4[r*BITS +: BITS] = b;
        op4[r*OPW +: OPW]  = op;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int exp_id [5];
        rst1 = 1'b1; rst4 = 1'b1;
        req1 = '0; req4 = '0; a1 = '0; b1 = '0; op1 = '0; a4 = '0; b4 = '0; op4 = '0;
        ready1 = 1'b0; ready4 = 1'b0;

        // Reset state
        smp();
        chk("rst_gnt", gnt1, 0);
        chk("rst_valid", valid1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_result", out1, 0);
        chk("rst_exe_a", ea1, 0);
        chk("rst_id", id1, 0);
        next();
        rst1 = 1'b0; rst4 = 1'b0;

        // Single request from requester 2, compare-equal
        next();
        req1 = 4'b0100;
        set1(2, 32'h0000_0005, 32'h0000_0005, OP_CMP_EQ);
        smp();
        chk("single_gnt", gnt1, 4'b0100);
        chk("single_busy_idle", busy1, 0);
        next();
        req1 = '0;
        smp();
        chk("single_gnt_exec", gnt1, 0);
        chk("single_busy_exec", busy1, 1);
        chk("single_exe_a", ea1, 32'h5);
        chk("single_exe_oper", eop1, OP_CMP_EQ);
        chk("single_valid_exec", valid1, 0);
        next();
        smp();
        chk("single_valid", valid1, 1);
        chk("single_id", id1, 2);
        chk("single_result", out1, 1);
        chk("single_exe_a_resp", ea1, 0);

        // Backpressure: response held, no grant despite all requests
        req1 = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            next();
            smp();
            chk("bp_valid", valid1, 1);
            chk("bp_id", id1, 2);
            chk("bp_result", out1, 1);
            chk("bp_gnt", gnt1, 0);
        end
        next();
        req1 = '0;
        ready1 = 1'b1;
        smp();
        chk("bp_handshake_valid", valid1, 1);
        next();
        smp();
        chk("bp_release_valid", valid1, 0);
        chk("bp_release_busy", busy1, 0);

        // Wrap-around: pointer is 3, only requester 0 asks
        next();
        req1 = 4'b0001;
        set1(0, 32'd7, 32'd9, OP_ADD);
        smp();
        chk("wrap_gnt", gnt1, 4'b0001);
        next();
        req1 = '0;
        next();
        smp();
        chk("wrap_valid", valid1, 1);
        chk("wrap_id", id1, 0);
        chk("wrap_result", out1, 32'd16);
        next();
        smp();
        chk("wrap_idle", valid1, 0);

        // Pointer now 1: requesters 0 and 3 ask, 3 is reached first
        next();
        req1 = 4'b1001;
        set1(3, 32'd10, 32'd3, OP_SUB);
        smp();
`ifdef EXE_ARB_PRIO_EN
        chk("ptr1_gnt", gnt1, 4'b0001);
`else
        chk("ptr1_gnt", gnt1, 4'b1000);
`endif
        next();
        req1 = '0;
        next();
        smp();
`ifdef EXE_ARB_PRIO_EN
        chk("ptr1_id", id1, 0);
        chk("ptr1_result", out1, 32'd16);
`else
        chk("ptr1_id", id1, 3);
        chk("ptr1_result", out1, 32'd7);
`endif
        next();

        // Fairness: all requesters held, ready held
`ifdef EXE_ARB_PRIO_EN
        exp_id = '{0, 0, 0, 0, 0};
`else
        exp_id = '{0, 1, 2, 3, 0};
`endif
        for (int r = 0; r < N; r++) set1(r, r, 32'h100, OP_ADD);
        req1 = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            do begin
                next();
                smp();
                n++;
            end while (!valid1 && n < 10);
            chk("rr_valid", valid1, 1);
            chk("rr_id", id1, exp_id[k]);
            chk("rr_result", out1, 32'h100 + exp_id[k]);
        end
        next();
        req1 = '0;

        // Operand stability with EXE_LAT=4
        next();
        req4 = 4'b0100;
        set4(2, 32'h1234_5678, 32'h1111_1111, OP_SUB);
        smp();
        chk("stab_gnt", gnt4, 4'b0100);
        next();
        req4 = '0;
        set4(2, 32'hFFFF_FFFF, 32'h1111_1111, OP_SUB);
        for (int i = 0; i < 4; i++) begin
            smp();
            chk("stab_exe_a", ea4, 32'h1234_5678);
            chk("stab_valid", valid4, 0);
            next();
        end
        ready4 = 1'b1;
        smp();
        chk("stab_valid_resp", valid4, 1);
        chk("stab_id", id4, 2);
        chk("stab_result", out4, 32'h0123_4567);
        chk("stab_exe_a_resp", ea4, 0);
        next();
        ready4 = 1'b0;

        // Reset mid-EXEC: operation from requester 1 is dropped
        req4 = 4'b0010;
        set4(1, 32'd1, 32'd2, OP_ADD);
        smp();
`ifdef EXE_ARB_PRIO_EN
        chk("mid_gnt", gnt4, 4'b0010);
`else
        chk("mid_gnt", gnt4, 4'b0010);
`endif
        next();
        req4 = 4'b1111;
        smp();
        chk("mid_busy", busy4, 1);
        next();
        rst4 = 1'b1;
        #1;
        chk("mid_rst_gnt", gnt4, 0);
        chk("mid_rst_busy", busy4, 0);
        chk("mid_rst_valid", valid4, 0);
        chk("mid_rst_exe_a", ea4, 0);
        chk("mid_rst_exe_oper", eop4, 0);
        chk("mid_rst_id", id4, 0);
        chk("mid_rst_result", out4, 0);
        next();
        rst4 = 1'b0;
        req4 = '0;
        ready4 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            smp();
            chk("post_rst_valid", valid4, 0);
            next();
        end
        req4 = 4'b1111;
        smp();
        chk("post_rst_gnt", gnt4, 4'b0001);
        next();
        req4 = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
